load_use_stall_unit: RTL and testbench

//  Producer-side companion to the EX-stage forwarding mux select logic. Tracks in-flight loads.

---
 rtl/load_use_stall_unit.sv | 70 +++++++
 tb/tb_load_use_stall_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/load_use_stall_unit.sv
// load_use_stall_unit: tracks in-flight loads, stalls dependent ID instructions and sequences IF/ID flushes on EX redirects.
module load_use_stall_unit #(
  parameter int LOAD_LAT       = 1,
  parameter int BRANCH_PENALTY = 1,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_id,
  input  logic [6:0]       opcode_id,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic [4:0]       rd_id,
  input  logic             mem_read_id,
  input  logic             redirect_ex,
  input  logic             perf_clr,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             load_pending,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam logic RUN   = 1'b0;
  localparam logic REDIR = 1'b1;
  logic [LOAD_LAT-1:0] vld_q, vld_d;
  logic [4:0]          rd_q [LOAD_LAT];
  logic [4:0]          rd_d [LOAD_LAT];
  logic                state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                use1, use2, hazard, flush, stall, ins;
  // Slot i holds the entry of age i+1, so aging is a shift and the oldest falls off.
  always_comb begin
    use1 = opcode_id inside {7'b0110011, 7'b1100011, 7'b0100011, 7'b0010011, 7'b0000011, 7'b1100111};
    use2 = opcode_id inside {7'b0110011, 7'b1100011, 7'b0100011};
    hazard = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++)
      hazard = hazard | (vld_q[i] & ((use1 & (rs1_id == rd_q[i])) | (use2 & (rs2_id == rd_q[i]))));
    hazard = hazard & valid_id;
    flush = redirect_ex | (state_q == REDIR);
    stall = hazard & ~flush;
    ins = valid_id & mem_read_id & (rd_id != 5'd0) & ~stall & ~flush;
    vld_d[0] = ins;
    rd_d[0] = rd_id;
    for (int i = 1; i < LOAD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      rd_d[i] = rd_q[i-1];
    end
    state_d = (redirect_ex && BRANCH_PENALTY == 2) ? REDIR : RUN;
    cnt_d = perf_clr ? '0 : (stall & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
    pc_write = rst_n & ~stall;
    ifid_write = rst_n & ~stall;
    idex_bubble = ~rst_n | stall | flush;
    ifid_flush = rst_n & flush;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < LOAD_LAT; i++) rd_q[i] <= '0;
      state_q <= RUN;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < LOAD_LAT; i++) rd_q[i] <= rd_d[i];
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  assign load_pending = |vld_q;
  assign stall_cycles = cnt_q;
endmodule

// File: tb/tb_load_use_stall_unit.sv
// tb_load_use_stall_unit: directed scoreboard bench over two configurations (LOAD_LAT=1/BP=1 and LOAD_LAT=3/BP=2, 4-bit counter).
module tb_load_use_stall_unit;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_S = 7'b0100011, OP_JAL = 7'b1101111;
  // Expected tuples are {pc_write, ifid_write, idex_bubble, ifid_flush, load_pending}.
  localparam logic [4:0] NRM = 5'b11000, NRP = 5'b11001, STL = 5'b00101,
                         FLP = 5'b11111, FL0 = 5'b11110, RST = 5'b00100;
  logic clk = 0, rst_n = 0, valid_id = 0, mem_read_id = 0, redirect_ex = 0, perf_clr = 0;
  logic [6:0] opcode_id = '0;
  logic [4:0] rs1_id = '0, rs2_id = '0, rd_id = '0;
  logic pw_a, iw_a, bub_a, fl_a, lp_a, pw_b, iw_b, bub_b, fl_b, lp_b;
  logic [15:0] sc_a;
  logic [3:0]  sc_b;
  typedef struct packed {logic [4:0] a; logic [4:0] b;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0, stp = 0;
  load_use_stall_unit #(.LOAD_LAT(1), .BRANCH_PENALTY(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .valid_id(valid_id), .opcode_id(opcode_id), .rs1_id(rs1_id),
    .rs2_id(rs2_id), .rd_id(rd_id), .mem_read_id(mem_read_id), .redirect_ex(redirect_ex),
    .perf_clr(perf_clr), .pc_write(pw_a), .ifid_write(iw_a), .idex_bubble(bub_a),
    .ifid_flush(fl_a), .load_pending(lp_a), .stall_cycles(sc_a));
  load_use_stall_unit #(.LOAD_LAT(3), .BRANCH_PENALTY(2), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .valid_id(valid_id), .opcode_id(opcode_id), .rs1_id(rs1_id),
    .rs2_id(rs2_id), .rd_id(rd_id), .mem_read_id(mem_read_id), .redirect_ex(redirect_ex),
    .perf_clr(perf_clr), .pc_write(pw_b), .ifid_write(iw_b), .idex_bubble(bub_b),
    .ifid_flush(fl_b), .load_pending(lp_b), .stall_cycles(sc_b));
  always #5 clk = ~clk;
  task automatic cmp(string tag, logic [15:0] obs, logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic pop_check();
    exp_t e;
    if (q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL step%0d_queue: observed empty expected entry", stp);
    end else begin
      e = q.pop_front();
      cmp($sformatf("step%0d_a", stp), {11'd0, pw_a, iw_a, bub_a, fl_a, lp_a}, {11'd0, e.a});
      cmp($sformatf("step%0d_b", stp), {11'd0, pw_b, iw_b, bub_b, fl_b, lp_b}, {11'd0, e.b});
    end
  endtask
  task automatic set_in(logic v, logic [6:0] op, logic [4:0] r1, logic [4:0] r2, logic [4:0] rd,
                        logic mr, logic rx);
    valid_id = v; opcode_id = op; rs1_id = r1; rs2_id = r2; rd_id = rd;
    mem_read_id = mr; redirect_ex = rx;
  endtask
  task automatic drv(logic v, logic [6:0] op, logic [4:0] r1, logic [4:0] r2, logic [4:0] rd,
                     logic mr, logic rx, logic [4:0] ea, logic [4:0] eb);
    stp++;
    set_in(v, op, r1, r2, rd, mr, rx);
    q.push_back('{ea, eb});
    @(negedge clk);
    pop_check();
    @(posedge clk);
    #1;
  endtask
  task automatic now(logic [4:0] ea, logic [4:0] eb);
    stp++;
    q.push_back('{ea, eb});
    pop_check();
  endtask
  task automatic cnt(logic [15:0] ea, logic [3:0] eb);
    cmp($sformatf("cnt%0d_a", stp), sc_a, ea);
    cmp($sformatf("cnt%0d_b", stp), {12'd0, sc_b}, {12'd0, eb});
  endtask
  task automatic ld(logic [4:0] rd, logic [4:0] r1, logic [4:0] ea, logic [4:0] eb);
    drv(1, OP_LD, r1, 5'd0, rd, 1, 0, ea, eb);
  endtask
  task automatic idle(logic rx, logic [4:0] ea, logic [4:0] eb);
    drv(0, OP_R, 5'd3, 5'd5, 5'd0, 0, rx, ea, eb);
  endtask
  initial begin
    #12;
    now(RST, RST);
    cnt(0, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    // lw x5 ; add x6,x5,x1
    ld(5, 2, NRM, NRM);
    drv(1, OP_R, 5, 1, 6, 0, 0, STL, STL);
    drv(1, OP_R, 5, 1, 6, 0, 0, NRM, STL);
    drv(1, OP_R, 5, 1, 6, 0, 0, NRM, STL);
    drv(1, OP_R, 5, 1, 6, 0, 0, NRM, NRM);
    cnt(1, 3);
    // one independent instruction in between
    ld(5, 2, NRM, NRM);
    drv(1, OP_I, 0, 0, 7, 0, 0, NRP, NRP);
    drv(1, OP_R, 5, 1, 6, 0, 0, NRM, STL);
    drv(1, OP_R, 5, 1, 6, 0, 0, NRM, STL);
    drv(1, OP_R, 5, 1, 6, 0, 0, NRM, NRM);
    cnt(1, 5);
    // lw x0 is never tracked
    ld(0, 2, NRM, NRM);
    drv(1, OP_R, 0, 0, 6, 0, 0, NRM, NRM);
    cnt(1, 5);
    // store uses rs2; jal uses nothing; invalid ID never stalls
    ld(3, 2, NRM, NRM);
    drv(1, OP_S, 5, 3, 0, 0, 0, STL, STL);
    drv(1, OP_S, 5, 3, 0, 0, 0, NRM, STL);
    drv(1, OP_S, 5, 3, 0, 0, 0, NRM, STL);
    drv(1, OP_S, 5, 3, 0, 0, 0, NRM, NRM);
    cnt(2, 8);
    ld(3, 2, NRM, NRM);
    drv(1, OP_JAL, 3, 3, 1, 0, 0, NRP, NRP);
    idle(0, NRM, NRP);
    idle(0, NRM, NRP);
    idle(0, NRM, NRM);
    cnt(2, 8);
    // back-to-back independent loads are both tracked
    ld(5, 2, NRM, NRM);
    ld(6, 2, NRP, NRP);
    drv(1, OP_R, 5, 0, 9, 0, 0, NRP, STL);
    drv(1, OP_R, 5, 0, 9, 0, 0, NRM, STL);
    drv(1, OP_R, 5, 0, 9, 0, 0, NRM, NRP);
    idle(0, NRM, NRM);
    cnt(2, 10);
    // hazard and redirect together: flush wins, no stall counted
    ld(5, 2, NRM, NRM);
    drv(1, OP_R, 5, 1, 6, 0, 1, FLP, FLP);
    idle(0, NRM, FLP);
    idle(0, NRM, NRP);
    idle(0, NRM, NRM);
    cnt(2, 10);
    // redirect arriving in REDIR re-enters it
    idle(1, FL0, FL0);
    idle(1, FL0, FL0);
    idle(0, NRM, FL0);
    idle(0, NRM, NRM);
    // counter saturation on the 4-bit instance
    for (int k = 0; k < 2; k++) begin
      ld(5, 2, NRM, NRM);
      drv(1, OP_R, 5, 1, 6, 0, 0, STL, STL);
      drv(1, OP_R, 5, 1, 6, 0, 0, NRM, STL);
      drv(1, OP_R, 5, 1, 6, 0, 0, NRM, STL);
      drv(1, OP_R, 5, 1, 6, 0, 0, NRM, NRM);
    end
    cnt(4, 15);
    // perf_clr beats a same-cycle increment
    ld(5, 2, NRM, NRM);
    perf_clr = 1;
    drv(1, OP_R, 5, 1, 6, 0, 0, STL, STL);
    perf_clr = 0;
    cnt(0, 0);
    drv(1, OP_R, 5, 1, 6, 0, 0, NRM, STL);
    cnt(0, 1);
    drv(1, OP_R, 5, 1, 6, 0, 0, NRM, STL);
    drv(1, OP_R, 5, 1, 6, 0, 0, NRM, NRM);
    cnt(0, 2);
    // asynchronous reset in the middle of a stall
    ld(5, 2, NRM, NRM);
    set_in(1, OP_R, 5, 1, 6, 0, 0);
    @(negedge clk);
    now(STL, STL);
    #2 rst_n = 0;
    #1;
    now(RST, RST);
    cnt(0, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    drv(1, OP_R, 5, 1, 6, 0, 0, NRM, NRM);
    cnt(0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
